// File: rtl/lcd_spi_rx_if.sv
// lcd_spi_rx_if: LCD serial pins plus the decoded receive-side results.
interface lcd_spi_rx_if;
  logic        cs;
  logic        dc;
  logic        sclk;
  logic        mosi;
  logic [8:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic        frame_err;

  // Write-engine side: drives the pins, observes the decoded results.
  modport master (
    output cs, dc, sclk, mosi,
    input  rx_data, rx_valid, cmd, pix_valid, pix_data, pix_x, pix_y, frame_err
  );

  // Receiver side.
  modport slave (
    input  cs, dc, sclk, mosi,
    output rx_data, rx_valid, cmd, pix_valid, pix_data, pix_x, pix_y, frame_err
  );
endinterface

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: receive-side model of the LCD 4-wire serial port. Recovers {dc, byte}
// words from the pins and decodes CASET/RASET/RAMWR into pixel writes with coordinates.
module lcd_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COL_MAX     = 239,
  parameter int unsigned ROW_MAX     = 319
) (
  input logic         sys_clk_50MHz,
  input logic         sys_rst,
  lcd_spi_rx_if.slave bus
);

  // Synchronizer flops followed by the two samples used for edge detection.
  localparam int unsigned PipeLen = SYNC_STAGES + 2;

  typedef enum logic [2:0] {
    StIdle, StCasetP, StRasetP, StRamwrHi, StRamwrLo, StIgnore
  } state_e;

  logic [PipeLen-1:0] cs_pipe, dc_pipe, sclk_pipe, mosi_pipe;
  logic cs_cur, cs_prev, sclk_cur, sclk_prev, dc_cur, mosi_cur;
  logic sclk_rise, cs_rise, cs_fall, bit_take;

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [8:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, cs_rise_q;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  hi_q, hi_d, cmd_q, cmd_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [8:0]  param;

  // Pin synchronizers; cs idles high so its chain resets to 1.
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      cs_pipe   <= '1;
      dc_pipe   <= '0;
      sclk_pipe <= '0;
      mosi_pipe <= '0;
    end else begin
      cs_pipe   <= {cs_pipe[PipeLen-2:0], bus.cs};
      dc_pipe   <= {dc_pipe[PipeLen-2:0], bus.dc};
      sclk_pipe <= {sclk_pipe[PipeLen-2:0], bus.sclk};
      mosi_pipe <= {mosi_pipe[PipeLen-2:0], bus.mosi};
    end
  end

  assign cs_cur    = cs_pipe[PipeLen-2];
  assign cs_prev   = cs_pipe[PipeLen-1];
  assign sclk_cur  = sclk_pipe[PipeLen-2];
  assign sclk_prev = sclk_pipe[PipeLen-1];
  assign dc_cur    = dc_pipe[PipeLen-2];
  assign mosi_cur  = mosi_pipe[PipeLen-2];
  assign sclk_rise = sclk_cur & ~sclk_prev;
  assign cs_rise   = cs_cur & ~cs_prev;
  assign cs_fall   = ~cs_cur & cs_prev;
  // A bit coinciding with the cs rising edge still belongs to the frame.
  assign bit_take  = sclk_rise & ~(cs_cur & cs_prev);

  // Bit capture: shift, count, emit the word on the 8th bit, flag truncated frames.
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (bit_take) begin
      shift_d = {shift_q[6:0], mosi_cur};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        rx_data_d  = {dc_cur, shift_q[6:0], mosi_cur};
        rx_valid_d = 1'b1;
      end
    end
    if (cs_rise && cnt_d != 3'd0) begin
      frame_err_d = 1'b1;
      cnt_d       = 3'd0;
    end
    if (cs_fall) cnt_d = 3'd0;
  end

  // Capture-stage registers; cs_rise is delayed to line up with rx_valid.
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      cs_rise_q   <= cs_rise;
    end
  end

  // 9-bit coordinate from the latched high byte and the current low byte.
  assign param = {hi_q[0], rx_data_q[7:0]};

  // Command decoder: next state, window, cursor and pixel output.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    cmd_d       = cmd_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    if (rx_valid_q) begin
      if (!rx_data_q[8]) begin
        cmd_d = rx_data_q[7:0];
        idx_d = 2'd0;
        case (rx_data_q[7:0])
          8'h2A:   state_d = StCasetP;
          8'h2B:   state_d = StRasetP;
          8'h2C: begin
            state_d = StRamwrHi;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: state_d = StIgnore;
        endcase
      end else begin
        unique case (state_q)
          StCasetP, StRasetP: begin
            idx_d = idx_q + 2'd1;
            if (!idx_q[0]) hi_d = rx_data_q[7:0];
            if (idx_q == 2'd1) begin
              if (state_q == StCasetP) xs_d = param;
              else                     ys_d = param;
            end
            if (idx_q == 2'd3) begin
              if (state_q == StCasetP) xe_d = param;
              else                     ye_d = param;
              state_d = StIdle;
            end
          end
          StRamwrHi: begin
            hi_d    = rx_data_q[7:0];
            state_d = StRamwrLo;
          end
          StRamwrLo: begin
            pix_valid_d = 1'b1;
            pix_data_d  = {hi_q, rx_data_q[7:0]};
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            state_d     = StRamwrHi;
            if (x_q == xe_q) begin
              x_d = xs_q;
              y_d = (y_q == ye_q) ? ys_q : y_q + 9'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
    // Ending the frame with only a high byte in hand drops that byte.
    if (cs_rise_q && state_d == StRamwrLo) state_d = StRamwrHi;
  end

  // Decoder registers.
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      hi_q        <= '0;
      cmd_q       <= '0;
      xs_q        <= '0;
      xe_q        <= 9'(COL_MAX);
      ys_q        <= '0;
      ye_q        <= 9'(ROW_MAX);
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      cmd_q       <= cmd_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.cmd       = cmd_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;

endmodule
